stream_rr_arbiter: RTL
======================

# stream_rr_arbiter

Packet-granular round-robin arbiter that merges NUM_IN independent 512-bit packet streams into the single input stream of the stream demultiplexer. A grant is held for a whole packet (sop through eop) so packets never interleave. A 2-entry output buffer decouples downstream backpressure from the input ready lines. Drop and packet counters are exported for the status block.

## Interface
Parameters:
- NUM_IN, 4: number of input streams (2..8).
- DATA_W, 512: beat width.
- EMPTY_W, 6: width of the empty field (log2 of DATA_W/8).

Ports (clock is `clk`; reset is `rst`, synchronous, active-high; one clock domain):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  NUM_IN*DATA_W  beat data; input i occupies slice [i*DATA_W +: DATA_W].
- in_valid  in  NUM_IN  beat valid, one bit per input.
- in_sop  in  NUM_IN  start of packet.
- in_eop  in  NUM_IN  end of packet.
- in_empty  in  NUM_IN*EMPTY_W  empty bytes in the eop beat.
- in_ready  out  NUM_IN  beat accepted when in_valid[i] & in_ready[i].
- out_data  out  DATA_W  merged beat data.
- out_valid  out  1  merged beat valid.
- out_sop  out  1  start of packet.
- out_eop  out  1  end of packet.
- out_empty  out  EMPTY_W  empty bytes in the eop beat.
- out_ready  in  1  downstream ready (ready latency 0).
- pkt_cnt  out  32  eop beats accepted from any input; wraps at 2^32.
- drop_cnt  out  32  beats dropped for protocol errors; wraps at 2^32.

## Operation
- State machine with two states, IDLE and LOCKED. Registers: `grant` (log2 NUM_IN bits) and `rr_ptr`.
- IDLE:
  - Search inputs starting at rr_ptr, ascending modulo NUM_IN, for the first i with in_valid[i] & in_sop[i].
  - If found: grant <= i, go to LOCKED. No beat is accepted in this cycle.
- IDLE drop rule: every input j with in_valid[j] & ~in_sop[j] gets in_ready[j]=1 in IDLE. Those beats are discarded, and drop_cnt increments by the number of such beats in that cycle.
- LOCKED:
  - in_ready[grant] = (fifo_count < 2). All other in_ready bits are 0.
  - Each accepted beat is written into the output buffer unchanged.
- Mid-packet sop: an accepted beat with sop=1 after the first beat of the packet is forwarded as-is and increments drop_cnt. It does not count as a drop of data.
- End of packet: when a beat with eop=1 is accepted, pkt_cnt increments, rr_ptr <= (grant+1) mod NUM_IN, and the state returns to IDLE.
- A single-beat packet (sop & eop together) is legal. It occupies one LOCKED cycle.
- Output buffer: a 2-entry FIFO of {data, sop, eop, empty}.
  - out_valid = (fifo_count != 0); the out_* fields show the head entry.
  - The head pops when out_valid & out_ready.
  - A push and a pop in the same cycle leave the count unchanged.
- Fairness: any input holding a valid sop is granted within NUM_IN-1 other packets.

## Timing
- Reset values: out_valid=0, in_ready=0, out_sop/out_eop/out_empty/out_data=0, state=IDLE, rr_ptr=0, grant=0, fifo_count=0, pkt_cnt=0, drop_cnt=0.
- in_ready is a function only of registered state (state, grant, fifo_count) plus the current in_valid/in_sop values. There is no combinational path from out_ready to in_ready.
- Latency: a beat accepted in cycle t appears on the out_* ports in cycle t+1 if the FIFO was empty.
- Per-packet overhead: one IDLE arbitration cycle. Sustained throughput is 1 beat/cycle within a packet.
- FIFO full (count=2): in_ready[grant]=0 until a pop is registered, so there is one bubble after backpressure releases.
- Reset mid-packet: everything clears in the following cycle, and buffered beats are discarded. Downstream may see a truncated packet. This is accepted behaviour.
- The counters saturate nowhere: 0xFFFFFFFF + 1 = 0.

## Structure
- Shared package `stream_arb_pkg`: typedef `stream_beat_t` {data[DATA_W], sop, eop, empty[EMPTY_W]} and the FSM state enum {ARB_IDLE, ARB_LOCKED}.
- One sub-module: `stream_skid_fifo`, a 2-entry FIFO parameterised on width, with count output, push/pop ports and synchronous active-high reset.
- Arbiter top: FSM, rotating priority search, counters and input muxing.

## Test plan
- Basic merge:
  - Stimulus: NUM_IN=4, input 2 sends a 3-beat packet (empty=5 on eop), out_ready=1.
  - Response: out beats identical, eop beat has empty=5, pkt_cnt=1, first out_valid 2 cycles after in_valid.
- Round-robin:
  - Stimulus: all four inputs hold 2-beat packets continuously.
  - Response: grant order 0,1,2,3,0,…; after 8 packets pkt_cnt=8 and no interleaved beats.
- Backpressure:
  - Stimulus: out_ready held 0 for 5 cycles during a 6-beat packet.
  - Response: fifo_count peaks at 2, in_ready[grant]=0, no beat lost or duplicated after release.
- Protocol errors:
  - Stimulus: input 1 sends valid without sop while IDLE; later a sop appears mid-packet on input 3.
  - Response: the first beat is dropped; drop_cnt=2 in total, and the mid-packet beat is still forwarded.
- Reset mid-packet:
  - Stimulus: assert rst for 1 cycle at beat 2 of a 4-beat packet.
  - Response: next cycle out_valid=0, all in_ready=0, counters=0, state IDLE; a new packet on input 0 is then granted first.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared types for the packet round-robin arbiter and its output buffer.
package stream_arb_pkg;

  localparam int unsigned ARB_DATA_W  = 512;
  localparam int unsigned ARB_EMPTY_W = 6;

  // Output buffer geometry: two entries, count spans 0..2.
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = 2;

  // One stream beat at the default bus geometry.
  typedef struct packed {
    logic [ARB_DATA_W-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [ARB_EMPTY_W-1:0] empty;
  } stream_beat_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO that decouples downstream backpressure from the arbiter.
module stream_skid_fifo
  import stream_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);

  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  // Push is ignored when full and pop when empty; simultaneous push/pop keeps count.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && (count_q != FULL_CNT);
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
  end

  // Storage, pointers and occupancy; reset discards any buffered beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_IN streams into one buffered stream.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned EMPTY_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  input  logic [NUM_IN-1:0]         in_sop,
  input  logic [NUM_IN-1:0]         in_eop,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  output logic [NUM_IN-1:0]         in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [EMPTY_W-1:0]        out_empty,
  input  logic                      out_ready,
  output logic [31:0]               pkt_cnt,
  output logic [31:0]               drop_cnt
);

  localparam int unsigned GRANT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned BEAT_W  = DATA_W + 2 + EMPTY_W;
  localparam logic [GRANT_W-1:0]    LAST_IN  = GRANT_W'(NUM_IN - 1);
  localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);

  arb_state_e           state_q, state_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic                 first_q, first_d;
  logic [31:0]          pkt_cnt_q, pkt_cnt_d;
  logic [31:0]          drop_cnt_q, drop_cnt_d;

  logic [DATA_W-1:0]    data_arr  [NUM_IN];
  logic [EMPTY_W-1:0]   empty_arr [NUM_IN];

  logic                  found_c;
  logic [GRANT_W-1:0]    pick_c;
  int unsigned           idx;
  logic [31:0]           idle_drops_c;
  logic                  accept_c;
  logic                  fifo_full;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [BEAT_W-1:0]     fifo_push_data;
  logic [BEAT_W-1:0]     fifo_head;
  logic                  fifo_pop;

  // Split the flat input buses into per-input views for the grant mux.
  for (genvar i = 0; i < int'(NUM_IN); i++) begin : g_unpack
    assign data_arr[i]  = in_data[i*DATA_W +: DATA_W];
    assign empty_arr[i] = in_empty[i*EMPTY_W +: EMPTY_W];
  end

  // Rotating priority search for the first valid sop at or after rr_ptr.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_IN) begin
        idx = idx - NUM_IN;
      end
      if (!found_c && in_valid[GRANT_W'(idx)] && in_sop[GRANT_W'(idx)]) begin
        found_c = 1'b1;
        pick_c  = GRANT_W'(idx);
      end
    end
  end

  // Beats without sop arriving while idle are swallowed and counted as drops.
  always_comb begin
    idle_drops_c = 32'($countones(in_valid & ~in_sop));
  end

  assign fifo_full = (fifo_count == FULL_CNT);
  assign accept_c  = (state_q == ARB_LOCKED) && in_valid[grant_q] && !fifo_full;

  // Ready depends only on registered state and the current valid/sop inputs.
  always_comb begin
    in_ready = '0;
    if (state_q == ARB_IDLE) begin
      in_ready = in_valid & ~in_sop;
    end else begin
      in_ready[grant_q] = !fifo_full;
    end
  end

  // Next-state: arbitration in IDLE, packet tracking and counters in LOCKED.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    first_d    = first_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        drop_cnt_d = drop_cnt_q + idle_drops_c;
        if (found_c) begin
          grant_d = pick_c;
          first_d = 1'b1;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (accept_c) begin
          first_d = 1'b0;
          // A repeated sop inside a packet is forwarded but flagged.
          if (in_sop[grant_q] && !first_q) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
          end
          if (in_eop[grant_q]) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            rr_ptr_d  = (grant_q == LAST_IN) ? '0 : grant_q + GRANT_W'(1);
            state_d   = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      first_q    <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      first_q    <= first_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign fifo_push_data = {data_arr[grant_q], in_sop[grant_q], in_eop[grant_q], empty_arr[grant_q]};
  assign fifo_pop       = out_valid && out_ready;

  stream_skid_fifo #(
    .WIDTH (BEAT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept_c),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign {out_data, out_sop, out_eop, out_empty} = fifo_head;
  assign out_valid = (fifo_count != '0);
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
